// File: rtl/riscv_pipe_ctrl.sv
// Pipeline hazard/control unit: stall, flush and PC-select for the
// five-stage core, with a small FSM tracking data-memory and mul/div waits.
module riscv_pipe_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  sft_rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_rd_wen,
  input  logic                  ex_mem_read,
  input  logic                  ex_mc_start,
  input  logic                  ex_mc_done,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  excep_valid,
  input  logic                  mret,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  stall_id_ex,
  output logic                  stall_ex_mem,
  output logic                  stall_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  flush_mem_wb,
  output logic [1:0]            pc_sel,
  output logic                  ex_mc_kill,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    MCWAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q;

  logic in_memw;
  logic c_trap, c_mret, c_memw, c_mcw;
  logic c_br, c_lu, rs1_hit, rs2_hit;
  logic hit_trap, hit_mret, hit_memw;
  logic hit_mcw, hit_br, hit_lu;

  assign in_memw = (state_q == MEMWAIT);

  assign rs1_hit = id_rs1_used &
                   (id_rs1_addr == ex_rd_addr);
  assign rs2_hit = id_rs2_used &
                   (id_rs2_addr == ex_rd_addr);

  assign c_trap = excep_valid & ~in_memw;
  assign c_mret = mret & ~in_memw;
  assign c_memw = ~mem_ready & (mem_req | in_memw);
  assign c_mcw  = ex_mc_start &
                  ~(ex_mc_done | seen_q);
  assign c_br   = ex_branch_taken;
  assign c_lu   = ex_mem_read & ex_rd_wen &
                  (ex_rd_addr != '0) &
                  (rs1_hit | rs2_hit);

  // Priority chain flattened into one-hot selects
  assign hit_trap = c_trap;
  assign hit_mret = c_mret & ~c_trap;
  assign hit_memw = c_memw & ~c_trap & ~c_mret;
  assign hit_mcw  = c_mcw & ~c_memw &
                    ~c_trap & ~c_mret;
  assign hit_br   = c_br & ~c_mcw & ~c_memw &
                    ~c_trap & ~c_mret;
  assign hit_lu   = c_lu & ~c_br & ~c_mcw &
                    ~c_memw & ~c_trap & ~c_mret;

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    pc_sel       = 2'd0;
    ex_mc_kill   = 1'b0;
    state_d      = RUN;
    seen_d       = 1'b0;
    unique case (1'b1)
      hit_trap: begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
        pc_sel       = 2'd2;
        ex_mc_kill   = 1'b1;
      end
      hit_mret: begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        pc_sel       = 2'd3;
      end
      hit_memw: begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
        state_d      = MEMWAIT;
        // EX is frozen, so a done pulse must be remembered
        seen_d       = seen_q | ex_mc_done;
      end
      hit_mcw: begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        state_d      = MCWAIT;
      end
      hit_br: begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        pc_sel       = 2'd1;
      end
      hit_lu: begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
      end
      default: ;
    endcase
    if (!sft_rst_n) begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
      pc_sel       = 2'd0;
      ex_mc_kill   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sft_rst_n) begin
    if (!sft_rst_n) begin
      state_q <= RUN;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      if (stall_pc && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ctrl_state = state_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Scoreboard bench for riscv_pipe_ctrl: directed hazard scenarios
// followed by protocol-aware random traffic against a rule model.
module tb_riscv_pipe_ctrl;

  localparam int AW = 5;
  localparam int CW = 5;

  typedef struct packed {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          wen;
    logic          ld;
    logic          mcs;
    logic          mcd;
    logic          br;
    logic          req;
    logic          rdy;
    logic          exc;
    logic          mret;
  } in_t;

  typedef struct packed {
    logic          s_pc;
    logic          s_ifid;
    logic          s_idex;
    logic          s_exmem;
    logic          s_memwb;
    logic          f_ifid;
    logic          f_idex;
    logic          f_exmem;
    logic          f_memwb;
    logic [1:0]    pcs;
    logic          kill;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  s;
  out_t got;

  always #5 clk = ~clk;

  riscv_pipe_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk),
    .sft_rst_n(rst_n),
    .id_rs1_addr(s.rs1),
    .id_rs2_addr(s.rs2),
    .id_rs1_used(s.u1),
    .id_rs2_used(s.u2),
    .ex_rd_addr(s.rd),
    .ex_rd_wen(s.wen),
    .ex_mem_read(s.ld),
    .ex_mc_start(s.mcs),
    .ex_mc_done(s.mcd),
    .ex_branch_taken(s.br),
    .mem_req(s.req),
    .mem_ready(s.rdy),
    .excep_valid(s.exc),
    .mret(s.mret),
    .stall_pc(got.s_pc),
    .stall_if_id(got.s_ifid),
    .stall_id_ex(got.s_idex),
    .stall_ex_mem(got.s_exmem),
    .stall_mem_wb(got.s_memwb),
    .flush_if_id(got.f_ifid),
    .flush_id_ex(got.f_idex),
    .flush_ex_mem(got.f_exmem),
    .flush_mem_wb(got.f_memwb),
    .pc_sel(got.pcs),
    .ex_mc_kill(got.kill),
    .ctrl_state(got.st),
    .stall_cnt(got.cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  out_t exp_q[$];

  // Reference model state
  bit m_memwait, m_mcwait, m_seen;
  int m_cnt;
  bit last_memw, last_trap;

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic out_t rst_vec();
    out_t o;
    o = '0;
    o.f_ifid = 1'b1;
    o.f_idex = 1'b1;
    o.f_exmem = 1'b1;
    o.f_memwb = 1'b1;
    return o;
  endfunction

  task automatic check(string nm, out_t g, out_t e);
    n_checks++;
    if (g !== e) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t",
               nm, g, e, $time);
    end
  endtask

  task automatic model_reset();
    m_memwait = 0;
    m_mcwait = 0;
    m_seen = 0;
    m_cnt = 0;
  endtask

  // Evaluate the hazard rules on the current stimulus
  function automatic out_t model(in_t v);
    out_t o;
    bit trap, mr, mw, mc, lu;
    o = '0;
    o.cnt = CW'(m_cnt);
    o.st = m_memwait ? 2'd1 : (m_mcwait ? 2'd2 : 2'd0);
    trap = v.exc && !m_memwait;
    mr = v.mret && !m_memwait;
    mw = !v.rdy && (v.req || m_memwait);
    mc = v.mcs && !(v.mcd || m_seen);
    lu = v.ld && v.wen && v.rd != 0 &&
         ((v.u1 && v.rs1 == v.rd) ||
          (v.u2 && v.rs2 == v.rd));
    last_memw = 0;
    last_trap = 0;
    if (trap) begin
      o.f_ifid = 1; o.f_idex = 1;
      o.f_exmem = 1; o.f_memwb = 1;
      o.pcs = 2; o.kill = 1;
      last_trap = 1;
    end else if (mr) begin
      o.f_ifid = 1; o.f_idex = 1; o.f_exmem = 1;
      o.pcs = 3;
    end else if (mw) begin
      o.s_pc = 1; o.s_ifid = 1;
      o.s_idex = 1; o.s_exmem = 1;
      o.f_memwb = 1;
      last_memw = 1;
    end else if (mc) begin
      o.s_pc = 1; o.s_ifid = 1; o.s_idex = 1;
      o.f_exmem = 1;
    end else if (v.br) begin
      o.f_ifid = 1; o.f_idex = 1;
      o.pcs = 1;
    end else if (lu) begin
      o.s_pc = 1; o.s_ifid = 1; o.f_idex = 1;
    end
    return o;
  endfunction

  task automatic advance(in_t v, out_t o);
    bit was_memw;
    was_memw = m_memwait;
    m_memwait = last_memw;
    m_mcwait = !last_trap && !last_memw && !was_memw
               ? (v.mcs && !(v.mcd || m_seen)) : 1'b0;
    if (!last_trap && !last_memw && was_memw)
      m_mcwait = v.mcs && !(v.mcd || m_seen) &&
                 !(v.mret);
    if (!last_trap && !last_memw && v.mret)
      m_mcwait = 0;
    m_seen = last_memw ? (m_seen || v.mcd) : 1'b0;
    if (o.s_pc && m_cnt < (1 << CW) - 1)
      m_cnt++;
  endtask

  task automatic cyc(in_t v);
    out_t o;
    @(posedge clk);
    #1;
    s = v;
    o = model(v);
    exp_q.push_back(o);
    advance(v, o);
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_out", got, e);
      end
    end
  end

  // Random traffic generator state
  bit mem_act, mc_act, mc_fired;
  int mem_left, mc_left;

  task automatic rand_cyc();
    in_t v;
    v = idle();
    if (!mem_act && $urandom_range(5) == 0) begin
      mem_act = 1;
      mem_left = $urandom_range(3);
    end
    if (!mc_act && $urandom_range(7) == 0) begin
      mc_act = 1;
      mc_fired = 0;
      mc_left = $urandom_range(5);
    end
    v.req = mem_act;
    v.rdy = !mem_act || mem_left == 0;
    v.mcs = mc_act;
    v.mcd = mc_act && !mc_fired && mc_left == 0;
    v.rs1 = AW'($urandom_range(3));
    v.rs2 = AW'($urandom_range(3));
    v.rd  = AW'($urandom_range(3));
    v.u1  = 1'($urandom_range(1));
    v.u2  = 1'($urandom_range(1));
    v.wen = 1'($urandom_range(1));
    v.ld  = 1'($urandom_range(1));
    v.br  = $urandom_range(7) == 0;
    if (!m_memwait) begin
      v.exc  = $urandom_range(24) == 0;
      v.mret = $urandom_range(24) == 0;
    end
    cyc(v);
    if (last_trap) begin
      mem_act = 0;
      mc_act = 0;
    end else begin
      if (mem_act) begin
        if (v.rdy) mem_act = 0;
        else mem_left--;
      end
      if (mc_act) begin
        if (v.mcd) mc_fired = 1;
        else if (!mc_fired) mc_left--;
        if (mc_fired && !last_memw) mc_act = 0;
      end
    end
  endtask

  initial begin : stim
    in_t v;
    s = idle();
    model_reset();
    #3;
    check("reset_state", got, rst_vec());
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Load-use on rs1, then rd = x0
    v = idle();
    v.ld = 1; v.wen = 1; v.rd = 5;
    v.rs1 = 5; v.u1 = 1;
    cyc(v);
    cyc(idle());
    v.rd = 0; v.rs1 = 0;
    cyc(v);
    cyc(idle());

    // Taken branch masks a load-use
    v = idle();
    v.ld = 1; v.wen = 1; v.rd = 7;
    v.rs2 = 7; v.u2 = 1; v.br = 1;
    cyc(v);
    cyc(idle());

    // Multi-cycle op, done 4 cycles after entry
    v = idle();
    v.mcs = 1;
    repeat (4) cyc(v);
    v.mcd = 1;
    cyc(v);
    cyc(idle());

    // Mem wait during MCWAIT, done pulse hidden by it
    v = idle();
    v.mcs = 1;
    cyc(v);
    v.req = 1; v.rdy = 0;
    cyc(v);
    v.mcd = 1;
    cyc(v);
    v.mcd = 0;
    cyc(v);
    v.rdy = 1;
    cyc(v);
    cyc(idle());

    // Trap while in MCWAIT, then mret
    v = idle();
    v.mcs = 1;
    cyc(v);
    v.exc = 1;
    cyc(v);
    cyc(idle());
    v = idle();
    v.mret = 1;
    cyc(v);
    cyc(idle());

    // Asynchronous reset in the middle of MEMWAIT
    v = idle();
    v.req = 1; v.rdy = 0;
    cyc(v);
    cyc(v);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", got, rst_vec());
    model_reset();
    s = idle();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) rand_cyc();
    repeat (2) cyc(idle());
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain left=%0d want=0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
